// File: rtl/vga_timing_generator.sv
// VGA/CRT timing generator: clock divider, x/y counters, syncs, events.
// Ports: clock, reset, enable in; pixel_tick, hsync, vsync, video_on,
//   xpos, ypos, line_end, frame_start out; frame_count out when
//   VGA_FRAME_COUNTER_EN is defined.
module vga_timing_generator #(
  parameter int WIDTH     = 10,
  parameter int DIVIDE    = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [WIDTH-1:0] xpos,
  output logic [WIDTH-1:0] ypos,
  output logic             line_end,
  output logic             frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0]       frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam int W1      = WIDTH + 1;

  localparam logic [DW-1:0]    DIV_LAST = DW'(DIVIDE - 1);
  localparam logic [WIDTH-1:0] X_LAST   = WIDTH'(H_TOTAL - 1);
  localparam logic [WIDTH-1:0] Y_LAST   = WIDTH'(V_TOTAL - 1);

  // One extra bit so region bounds equal to 2**WIDTH stay representable.
  localparam logic [WIDTH:0] H_ACT  = W1'(H_ACTIVE);
  localparam logic [WIDTH:0] HS_BEG = W1'(H_ACTIVE + H_FP);
  localparam logic [WIDTH:0] HS_END = W1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [WIDTH:0] V_ACT  = W1'(V_ACTIVE);
  localparam logic [WIDTH:0] VS_BEG = W1'(V_ACTIVE + V_FP);
  localparam logic [WIDTH:0] VS_END = W1'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]    r_div;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_hs;
  logic             r_vs;
  logic             r_vid;
  logic             r_fs;

  logic             w_tick;
  logic             w_x_last;
  logic             w_y_last;
  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic [WIDTH:0]   w_xe;
  logic [WIDTH:0]   w_ye;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_vid;

  assign w_tick   = enable && !reset && (r_div == DIV_LAST);
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_tick) begin
      if (w_x_last) begin
        w_x_nxt = '0;
        w_y_nxt = w_y_last ? '0 : r_y + 1'b1;
      end else begin
        w_x_nxt = r_x + 1'b1;
      end
    end
  end

  // Decode from next-state so the registered flags line up with xpos/ypos.
  assign w_xe     = {1'b0, w_x_nxt};
  assign w_ye     = {1'b0, w_y_nxt};
  assign w_hs_act = (w_xe >= HS_BEG) && (w_xe < HS_END);
  assign w_vs_act = (w_ye >= VS_BEG) && (w_ye < VS_END);
  assign w_vid    = (w_xe < H_ACT) && (w_ye < V_ACT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_hs  <= ~HSYNC_POL;
      r_vs  <= ~VSYNC_POL;
      r_vid <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      if (enable) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      end
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      // With enable low the next-state equals the current state, so
      // these hold; right after reset they pick up the (0,0) decode.
      r_hs  <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
      r_vs  <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
      r_vid <= w_vid;
      r_fs  <= w_tick && w_x_last && w_y_last;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] r_fc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fc <= '0;
    end else if (w_tick && w_x_last && w_y_last) begin
      r_fc <= r_fc + 8'd1;
    end
  end

  assign frame_count = r_fc;
`endif

  assign pixel_tick  = w_tick;
  assign line_end    = w_tick && w_x_last;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign video_on    = r_vid;
  assign xpos        = r_x;
  assign ypos        = r_y;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: a divide-by-4 active-low unit
// and a divide-by-1 active-high unit on small timings, same clock/controls.
module tb_vga_timing_generator;

  logic clk;
  logic rst;
  logic en;

  logic       a_tick, a_hs, a_vs, a_vid, a_le, a_fs;
  logic [5:0] a_x, a_y;
  logic       b_tick, b_hs, b_vs, b_vid, b_le, b_fs;
  logic [3:0] b_x, b_y;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] a_fc;
  logic [7:0] b_fc;
`endif

  int n_chk;
  int n_fail;
  int run;
  bit adv;
  bit lrst;

  // A: 16 px/line (8/2/3/3), 8 lines (4/1/2/1), /4, active-low.
  vga_timing_generator #(
    .WIDTH(6), .DIVIDE(4),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_a (
    .clock(clk), .reset(rst), .enable(en),
    .pixel_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vid), .xpos(a_x), .ypos(a_y),
    .line_end(a_le), .frame_start(a_fs)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(a_fc)
`endif
  );

  // B: 10 px/line (6/1/2/1), 6 lines (3/1/1/1), /1, active-high.
  vga_timing_generator #(
    .WIDTH(4), .DIVIDE(1),
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (
    .clock(clk), .reset(rst), .enable(en),
    .pixel_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vid), .xpos(b_x), .ypos(b_y),
    .line_end(b_le), .frame_start(b_fs)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(b_fc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // run = number of enabled, non-reset clocks since the last reset.
  task automatic step();
    bit e;
    bit r;
    e = en && !rst;
    r = rst;
    @(posedge clk);
    #1;
    lrst = r;
    adv  = e;
    if (r) run = 0;
    else if (e) run++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    step();
    step();
    n_chk++;
    if ({a_x, a_y, a_hs, a_vs, a_vid, a_fs, a_tick, a_le} !==
        {6'd0, 6'd0, 1'b1, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_A got x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b tk=%b le=%b exp 0 0 1 1 0 0 0 0",
               a_x, a_y, a_hs, a_vs, a_vid, a_fs, a_tick, a_le);
    end
    n_chk++;
    if ({b_x, b_y, b_hs, b_vs, b_vid, b_fs, b_tick, b_le} !==
        {4'd0, 4'd0, 1'b0, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_B got x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b tk=%b le=%b exp all 0",
               b_x, b_y, b_hs, b_vs, b_vid, b_fs, b_tick, b_le);
    end
`ifdef VGA_FRAME_COUNTER_EN
    n_chk++;
    if (b_fc !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_fc got %0d exp 0", b_fc);
    end
`endif
  endtask

  task automatic test_release();
    rst = 1'b0;
    step();
    n_chk++;
    if ({a_vid, a_x, a_tick, a_fs} !== {1'b1, 6'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL release1_A got vid=%b x=%0d tk=%b fs=%b exp 1 0 0 0",
               a_vid, a_x, a_tick, a_fs);
    end
    n_chk++;
    if ({b_vid, b_x, b_tick} !== {1'b1, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL release1_B got vid=%b x=%0d tk=%b exp 1 1 1",
               b_vid, b_x, b_tick);
    end
    step();
    n_chk++;
    if (a_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL release2_tick got %b exp 0", a_tick);
    end
    step();
    n_chk++;
    if ({a_tick, a_x} !== {1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL release3 got tk=%b x=%0d exp 1 0", a_tick, a_x);
    end
    step();
    n_chk++;
    if ({a_tick, a_x} !== {1'b0, 6'd1}) begin
      n_fail++;
      $display("FAIL release4 got tk=%b x=%0d exp 0 1", a_tick, a_x);
    end
  endtask

  task automatic test_hsync();
    int xi;
    int hs_low;
    logic [5:0] ex;
    logic ehs, evid, etk, ele;
    hs_low = 0;
    for (int i = 0; i < 200 && run != 68; i++) begin
      step();
      xi   = (run / 4) % 16;
      ex   = 6'(xi);
      ehs  = !(xi >= 10 && xi <= 12);
      evid = (xi < 8);
      etk  = (run % 4 == 3);
      ele  = etk && (xi == 15);
      if (a_hs === 1'b0) hs_low++;
      n_chk++;
      if ({a_x, a_hs, a_vid, a_tick, a_le} !== {ex, ehs, evid, etk, ele}) begin
        n_fail++;
        $display("FAIL hline run=%0d got x=%0d hs=%b vid=%b tk=%b le=%b exp %0d %b %b %b %b",
                 run, a_x, a_hs, a_vid, a_tick, a_le, ex, ehs, evid, etk, ele);
      end
    end
    n_chk++;
    if (hs_low !== 12) begin
      n_fail++;
      $display("FAIL hsync_width got %0d clocks exp 12", hs_low);
    end
  endtask

  task automatic test_frame();
    int xi, yi, bx, by, fs_cnt, le_cnt, bfs_cnt;
    logic [5:0] ex, ey;
    logic [3:0] fx, fy;
    logic ehs, evs, evid, etk, ele, efs;
    logic fhs, fvs, fvid, fle, ffs;
    fs_cnt  = 0;
    le_cnt  = 0;
    bfs_cnt = 0;
    for (int i = 0; i < 3000 && run != 1600; i++) begin
      step();
      xi   = (run / 4) % 16;
      yi   = (run / 64) % 8;
      ex   = 6'(xi);
      ey   = 6'(yi);
      ehs  = !(xi >= 10 && xi <= 12);
      evs  = !(yi >= 5 && yi <= 6);
      evid = (xi < 8) && (yi < 4);
      etk  = (run % 4 == 3);
      ele  = etk && (xi == 15) ;
      efs  = adv && (run % 512 == 0);
      if (a_fs === 1'b1) fs_cnt++;
      if (a_le === 1'b1) le_cnt++;
      if (b_fs === 1'b1) bfs_cnt++;
      n_chk++;
      if ({a_x, a_y, a_hs, a_vs, a_vid, a_tick, a_le, a_fs} !==
          {ex, ey, ehs, evs, evid, etk, ele, efs}) begin
        n_fail++;
        $display("FAIL frame_A run=%0d got x=%0d y=%0d hs=%b vs=%b vid=%b tk=%b le=%b fs=%b exp %0d %0d %b %b %b %b %b %b",
                 run, a_x, a_y, a_hs, a_vs, a_vid, a_tick, a_le, a_fs,
                 ex, ey, ehs, evs, evid, etk, ele, efs);
      end
      bx   = run % 10;
      by   = (run / 10) % 6;
      fx   = 4'(bx);
      fy   = 4'(by);
      fhs  = (bx >= 7 && bx <= 8);
      fvs  = (by == 4);
      fvid = (bx < 6) && (by < 3);
      fle  = (bx == 9);
      ffs  = adv && (run % 60 == 0);
      n_chk++;
      if ({b_x, b_y, b_hs, b_vs, b_vid, b_tick, b_le, b_fs} !==
          {fx, fy, fhs, fvs, fvid, 1'b1, fle, ffs}) begin
        n_fail++;
        $display("FAIL frame_B run=%0d got x=%0d y=%0d hs=%b vs=%b vid=%b tk=%b le=%b fs=%b exp %0d %0d %b %b %b 1 %b %b",
                 run, b_x, b_y, b_hs, b_vs, b_vid, b_tick, b_le, b_fs,
                 fx, fy, fhs, fvs, fvid, fle, ffs);
      end
`ifdef VGA_FRAME_COUNTER_EN
      n_chk++;
      if ({a_fc, b_fc} !== {8'(run / 512), 8'(run / 60)}) begin
        n_fail++;
        $display("FAIL frame_count run=%0d got A=%0d B=%0d exp %0d %0d",
                 run, a_fc, b_fc, run / 512, run / 60);
      end
      if (run == 180) begin
        n_chk++;
        if (b_fc !== 8'd3) begin
          n_fail++;
          $display("FAIL fc_after_3 got %0d exp 3", b_fc);
        end
      end
`endif
    end
    n_chk++;
    if (fs_cnt !== 3) begin
      n_fail++;
      $display("FAIL fs_count_A got %0d exp 3", fs_cnt);
    end
    n_chk++;
    if (le_cnt !== 24) begin
      n_fail++;
      $display("FAIL le_count_A got %0d exp 24", le_cnt);
    end
    n_chk++;
    if (bfs_cnt !== 25) begin
      n_fail++;
      $display("FAIL fs_count_B got %0d exp 25", bfs_cnt);
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 200 && run != 1621; i++) step();
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_chk++;
      if ({a_x, a_y, a_hs, a_vid, a_tick, a_le, a_fs} !==
          {6'd5, 6'd1, 1'b1, 1'b1, 3'b000}) begin
        n_fail++;
        $display("FAIL pause_A i=%0d got x=%0d y=%0d hs=%b vid=%b tk=%b le=%b fs=%b exp 5 1 1 1 0 0 0",
                 i, a_x, a_y, a_hs, a_vid, a_tick, a_le, a_fs);
      end
      n_chk++;
      if ({b_x, b_y, b_tick, b_le} !== {4'd1, 4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL pause_B i=%0d got x=%0d y=%0d tk=%b le=%b exp 1 0 0 0",
                 i, b_x, b_y, b_tick, b_le);
      end
    end
    en = 1'b1;
    step();
    n_chk++;
    if ({a_x, a_tick} !== {6'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL resume1 got x=%0d tk=%b exp 5 0", a_x, a_tick);
    end
    step();
    n_chk++;
    if ({a_x, a_tick} !== {6'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL resume2 got x=%0d tk=%b exp 5 1", a_x, a_tick);
    end
    step();
    n_chk++;
    if ({a_x, a_tick, b_x} !== {6'd6, 1'b0, 4'd4}) begin
      n_fail++;
      $display("FAIL resume3 got x=%0d tk=%b bx=%0d exp 6 0 4", a_x, a_tick, b_x);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 1000 && run != 1965; i++) step();
    n_chk++;
    if ({a_x, a_y, a_hs, a_vs} !== {6'd11, 6'd6, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL pre_reset got x=%0d y=%0d hs=%b vs=%b exp 11 6 0 0",
               a_x, a_y, a_hs, a_vs);
    end
    rst = 1'b1;
    step();
    n_chk++;
    if ({a_x, a_y, a_hs, a_vs, a_vid, a_fs, a_tick, a_le} !==
        {6'd0, 6'd0, 1'b1, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL mid_reset_A got x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b tk=%b le=%b exp 0 0 1 1 0 0 0 0",
               a_x, a_y, a_hs, a_vs, a_vid, a_fs, a_tick, a_le);
    end
    n_chk++;
    if ({b_x, b_y, b_hs, b_vs, b_vid, b_tick} !== {4'd0, 4'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL mid_reset_B got x=%0d y=%0d hs=%b vs=%b vid=%b tk=%b exp all 0",
               b_x, b_y, b_hs, b_vs, b_vid, b_tick);
    end
    step();
    rst = 1'b0;
    step();
    n_chk++;
    if ({a_vid, a_x, a_y, a_fs} !== {1'b1, 6'd0, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset got vid=%b x=%0d y=%0d fs=%b exp 1 0 0 0",
               a_vid, a_x, a_y, a_fs);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    run    = 0;
    adv    = 1'b0;
    lrst   = 1'b0;
    rst    = 1'b1;
    en     = 1'b0;
    test_reset();
    test_release();
    test_hsync();
    test_frame();
    test_pause();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
